mb_uart_rx_param: RTL

Parametrised Modbus RTU UART receiver, next generation of the single-format 8N1 receiver. Supports configurable data width, parity and stop bits, and reports parity and framing errors per character. Detects the RTU inter-frame silent interval (t3.5) and pulses an end-of-frame strobe. Sits between the RS-485 pin and the Modbus frame assembler/CRC checker.

---
 rtl/mb_uart_rx_param.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mb_uart_rx_param.sv
// mb_uart_rx_param: Modbus RTU UART receiver with configurable data/parity/stop bits and t3.5 frame_end strobe.
// Optional `define MB_RX_MAJORITY_EN: 2-of-3 vote around mid-bit instead of one sample (one cycle more latency).
module mb_uart_rx_param #(
    parameter int CLK_FREQ  = 50000000,
    parameter int UART_BPS  = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 2,
    parameter int STOP_BITS = 1,
    parameter int GAP_BITS  = 38
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rxd,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 frame_end,
    output logic                 busy
);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CW      = $clog2(BPS_CNT);
    localparam int GW      = $clog2(GAP_BITS * BPS_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BPS_CNT - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(BPS_CNT / 2);
    localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_BITS * BPS_CNT);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY == 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [1:0]           r_sync;
    logic                 r_prev;
    logic [2:0]           r_state;
    logic [CW-1:0]        r_clk_cnt;
    logic [3:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bad;
    logic                 r_stop_bad;
    logic [GW-1:0]        r_gap;
    logic                 r_armed;
    logic                 w_rxs;
    logic                 w_fall;
    logic                 w_samp;
    logic                 w_bit;

    assign w_rxs  = r_sync[1];
    assign w_fall = r_prev & ~w_rxs;
    assign busy   = r_state != S_IDLE;

    // Synchroniser resets to idle-high so reset release never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], uart_rxd};
            r_prev <= w_rxs;
        end
    end

`ifdef MB_RX_MAJORITY_EN
    logic [1:0] r_maj;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_maj <= 2'b11;
        else begin
            if (r_clk_cnt == CNT_MID - 1'b1) r_maj[0] <= w_rxs;
            if (r_clk_cnt == CNT_MID) r_maj[1] <= w_rxs;
        end
    end
    assign w_samp = r_clk_cnt == CNT_MID + 1'b1;
    assign w_bit  = (r_maj[0] & r_maj[1]) | (w_rxs & (r_maj[0] | r_maj[1]));
`else
    assign w_samp = r_clk_cnt == CNT_MID;
    assign w_bit  = w_rxs;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_stop_bad <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_clk_cnt  <= (r_state == S_IDLE || r_clk_cnt == CNT_LAST) ? '0 : r_clk_cnt + 1'b1;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            case (r_state)
                S_IDLE: if (w_fall) r_state <= S_START;
                S_START: if (w_samp) begin
                    r_state    <= w_bit ? S_IDLE : S_DATA;
                    r_bit_idx  <= '0;
                    r_par_bad  <= 1'b0;
                    r_stop_bad <= 1'b0;
                end
                S_DATA: if (w_samp) begin
                    r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                    r_bit_idx <= (r_bit_idx == LAST_DATA) ? '0 : r_bit_idx + 1'b1;
                    if (r_bit_idx == LAST_DATA) r_state <= (PARITY != 0) ? S_PAR : S_STOP;
                end
                S_PAR: if (w_samp) begin
                    r_par_bad <= w_bit != (^r_shift ^ ODD);
                    r_state   <= S_STOP;
                end
                S_STOP: if (w_samp) begin
                    r_stop_bad <= r_stop_bad | ~w_bit;
                    r_bit_idx  <= r_bit_idx + 1'b1;
                    // Leave at mid-stop so an immediately following start bit is caught
                    if (r_bit_idx == LAST_STOP) begin
                        r_state    <= S_IDLE;
                        rx_valid   <= 1'b1;
                        rx_data    <= r_shift;
                        parity_err <= r_par_bad;
                        frame_err  <= r_stop_bad | ~w_bit;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gap timer saturates at threshold; arm flag limits frame_end to once per burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap     <= '0;
            r_armed   <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            r_gap     <= (busy || !w_rxs) ? '0 : (r_gap == GAP_MAX) ? r_gap : r_gap + 1'b1;
            frame_end <= r_armed && r_gap == GAP_MAX;
            r_armed   <= rx_valid || (r_armed && r_gap != GAP_MAX);
        end
    end
endmodule
